// File: rtl/usbhost_bus_bridge_if.sv
// Avalon-MM bus bundle shared by both sides of the USB host bridge.
// The same interface is used at 32-bit/6-bit width upstream and 8-bit/8-bit width downstream.
interface usbhost_bus_bridge_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic            chipselect;
  logic [AW-1:0]   address;
  logic [DW/8-1:0] byteenable;
  logic            read;
  logic            write;
  logic [DW-1:0]   writedata;
  logic [DW-1:0]   readdata;
  logic            waitrequest;
  logic            irq;

  modport master (
    output chipselect, address, byteenable, read, write, writedata,
    input  readdata, waitrequest, irq
  );

  modport slave (
    input  chipselect, address, byteenable, read, write, writedata,
    output readdata, waitrequest, irq
  );
endinterface

// File: rtl/usbhost_bus_bridge.sv
// 32-bit Avalon-MM slave to 8-bit Avalon-MM master bridge with a per-byte hang timeout.
// Optional macro USBHOST_BRIDGE_FIFOPORT_EN maps the FIFO word window onto one byte address.
module usbhost_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [5:0]  FIFO_WORD_ADDR = 6'h3F,
  parameter logic [7:0]  FIFO_BYTE_ADDR = 8'h20
) (
  input  logic                  avs_s1_clk,
  input  logic                  avs_s1_reset,
  usbhost_bus_bridge_if.slave   s1,
  usbhost_bus_bridge_if.master  m1,
  input  logic                  err_clr,
  output logic                  err_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t        state;
  logic [5:0]    addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic [1:0]    lane;
  logic [CW-1:0] to_cnt;

  logic          req;
  logic          to_hit;
  logic          lane_done;
  logic [1:0]    first_lane;
  logic          nxt_vld;
  logic [1:0]    nxt_lane;

  function automatic logic [7:0] byte_addr(input logic [5:0] a, input logic [1:0] l);
`ifdef USBHOST_BRIDGE_FIFOPORT_EN
    return (a == FIFO_WORD_ADDR) ? FIFO_BYTE_ADDR : {a, l};
`else
    return {a, l};
`endif
  endfunction

  assign req       = s1.chipselect && (s1.read || s1.write);
  assign to_hit    = (TIMEOUT_CYCLES != 0) && (state == ISSUE) && m1.waitrequest &&
                     (to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign lane_done = (state == ISSUE) && (!m1.waitrequest || to_hit);
  assign m1.byteenable = '1;

  // Lowest enabled lane of the incoming request, and next enabled lane above the current one.
  always_comb begin
    first_lane = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (s1.byteenable[i]) first_lane = 2'(i);
    nxt_vld  = 1'b0;
    nxt_lane = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (be_q[i] && (i > int'(lane))) begin
        nxt_vld  = 1'b1;
        nxt_lane = 2'(i);
      end
  end

  always_ff @(posedge avs_s1_clk or posedge avs_s1_reset) begin
    if (avs_s1_reset) begin
      state          <= IDLE;
      addr_q         <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      wr_q           <= 1'b0;
      lane           <= 2'd0;
      to_cnt         <= '0;
      s1.waitrequest <= 1'b1;
      s1.readdata    <= '0;
      s1.irq         <= 1'b0;
      err_o          <= 1'b0;
      m1.chipselect  <= 1'b0;
      m1.read        <= 1'b0;
      m1.write       <= 1'b0;
      m1.address     <= '0;
      m1.writedata   <= '0;
    end else begin
      s1.irq <= m1.irq;

      // A timeout in the same cycle as a clear keeps the flag set.
      if (to_hit)       err_o <= 1'b1;
      else if (err_clr) err_o <= 1'b0;

      case (state)
        IDLE: begin
          if (req) begin
            addr_q      <= s1.address;
            be_q        <= s1.byteenable;
            wdata_q     <= s1.writedata;
            wr_q        <= s1.write;
            s1.readdata <= '0;
            to_cnt      <= '0;
            if (s1.byteenable == 4'h0) begin
              state          <= DONE;
              s1.waitrequest <= 1'b0;
            end else begin
              state         <= ISSUE;
              lane          <= first_lane;
              m1.chipselect <= 1'b1;
              m1.read       <= !s1.write;
              m1.write      <= s1.write;
              m1.address    <= byte_addr(s1.address, first_lane);
              m1.writedata  <= s1.writedata[8*first_lane +: 8];
            end
          end
        end

        ISSUE: begin
          if (lane_done) begin
            s1.readdata[8*lane +: 8] <= to_hit ? 8'hFF : m1.readdata;
            to_cnt <= '0;
            if (nxt_vld) begin
              // Strobes stay up so the next byte goes out back-to-back.
              lane         <= nxt_lane;
              m1.address   <= byte_addr(addr_q, nxt_lane);
              m1.writedata <= wdata_q[8*nxt_lane +: 8];
            end else begin
              state          <= DONE;
              s1.waitrequest <= 1'b0;
              m1.chipselect  <= 1'b0;
              m1.read        <= 1'b0;
              m1.write       <= 1'b0;
            end
          end else if (m1.waitrequest) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        DONE: begin
          state          <= IDLE;
          s1.waitrequest <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usbhost_bus_bridge.sv
// Directed bench for usbhost_bus_bridge: an access-level model predicts byte traffic,
// completion cycle and assembled data; a negedge process compares the DUT every cycle.
module tb_usbhost_bus_bridge;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst;
  logic err_clr;
  logic err_o;

  usbhost_bus_bridge_if #(.AW(6), .DW(32)) s1();
  usbhost_bus_bridge_if #(.AW(8), .DW(8))  m1();

  usbhost_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .avs_s1_clk   (clk),
    .avs_s1_reset (rst),
    .s1           (s1),
    .m1           (m1),
    .err_clr      (err_clr),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream byte slave: fixed memory, programmable stall, optional hang.
  logic [7:0]  mem [256];
  int          wcnt    = 0;
  int          stall_n = 0;
  bit          stuck   = 1'b0;
  logic [16:0] log_q [$];

  assign m1.waitrequest = m1.chipselect && (stuck || (wcnt < stall_n));
  assign m1.readdata    = mem[m1.address];

  always @(posedge clk) begin
    if (m1.chipselect && !m1.waitrequest) begin
      wcnt <= 0;
      log_q.push_back({m1.write, m1.address, m1.write ? m1.writedata : m1.readdata});
    end else if (m1.chipselect) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Expected upstream timing/data for the access in flight.
  bit          active = 1'b0;
  bit          chk_rd = 1'b0;
  bit          err_exp = 1'b0;
  int          edge_cnt = 0;
  int          exp_done = 0;
  logic [31:0] exp_rd = '0;
  logic        irq_d;

  always @(posedge clk) begin
    if (active) edge_cnt <= edge_cnt + 1;
    else edge_cnt <= 0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) irq_d <= 1'b0;
    else irq_d <= m1.irq;
  end

  always @(negedge clk) begin
    if (!rst) check("irq", s1.irq, irq_d);
    if (active) begin
      check("waitrequest", s1.waitrequest, (edge_cnt + 1) != exp_done);
      if ((edge_cnt + 1) == exp_done && chk_rd) check("readdata", s1.readdata, exp_rd);
    end
  end

  task automatic access(input bit wr, input bit rd, input logic [5:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input int stall, input bit stk);
    logic [16:0] exp_q [$];
    logic [7:0]  b;
    int          n = 0;
    exp_rd = '0;
    for (int l = 0; l < 4; l++) begin
      if (be[l]) begin
        n++;
        b = wr ? wd[8*l +: 8] : mem[{a, l[1:0]}];
        if (!stk) exp_q.push_back({wr, a, l[1:0], b});
        exp_rd[8*l +: 8] = stk ? 8'hFF : b;
      end
    end
    exp_done = (n == 0) ? 2 : 2 + n * (stk ? T : stall + 1);
    if (stk) err_exp = 1'b1;
    chk_rd = !wr;

    @(negedge clk);
    log_q.delete();
    stall_n = stall;
    stuck   = stk;
    s1.chipselect = 1'b1; s1.read = rd; s1.write = wr;
    s1.address = a; s1.byteenable = be; s1.writedata = wd;
    active = 1'b1;
    @(negedge clk);
    // Once latched, the request fields must no longer matter.
    s1.address = ~a; s1.byteenable = ~be; s1.writedata = ~wd;
    while (edge_cnt < exp_done) @(negedge clk);
    s1.chipselect = 1'b0; s1.read = 1'b0; s1.write = 1'b0;
    active = 1'b0;
    stuck  = 1'b0;

    check("dn_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check("dn_access", log_q[i], exp_q[i]);
    check("err_o", err_o, err_exp);
    @(posedge clk);
  endtask

  logic [5:0] irq_pat;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    mem[0] = 8'h5A;

    rst = 1'b1; err_clr = 1'b0; m1.irq = 1'b0;
    s1.chipselect = 1'b0; s1.read = 1'b0; s1.write = 1'b0;
    s1.address = '0; s1.byteenable = '0; s1.writedata = '0;
    repeat (2) @(negedge clk);
    check("rst_waitreq", s1.waitrequest, 1'b1);
    check("rst_readdata", s1.readdata, 32'h0);
    check("rst_irq", s1.irq, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_m1_strobes", {m1.chipselect, m1.read, m1.write}, 3'b000);
    check("rst_m1_addr", m1.address, 8'h00);
    check("rst_m1_wdata", m1.writedata, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 4-lane zero-wait read
    access(1'b0, 1'b1, 6'h01, 4'hF, 32'h0, 0, 1'b0);
    check("t1_readdata_lit", s1.readdata, 32'h44332211);
    check("t1_first_lit", log_q[0], {1'b0, 8'h04, 8'h11});
    check("t1_last_lit", log_q[3], {1'b0, 8'h07, 8'h44});

    // sparse write
    access(1'b1, 1'b0, 6'h00, 4'b1010, 32'hA5B6C7D8, 0, 1'b0);
    check("t2_count_lit", log_q.size(), 2);
    check("t2_first_lit", log_q[0], {1'b1, 8'h01, 8'hC7});
    check("t2_second_lit", log_q[1], {1'b1, 8'h03, 8'hA5});

    // stretched single-lane read
    access(1'b0, 1'b1, 6'h00, 4'h1, 32'h0, 3, 1'b0);
    check("t3_readdata_lit", s1.readdata, 32'h0000005A);
    check("t3_err_lit", err_o, 1'b0);

    // hung slave: both lanes time out
    access(1'b0, 1'b1, 6'h02, 4'h3, 32'h0, 0, 1'b1);
    check("t4_readdata_lit", s1.readdata, 32'h0000FFFF);
    check("t4_err_lit", err_o, 1'b1);
    repeat (3) @(negedge clk);
    check("t4_err_sticky", err_o, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    err_exp = 1'b0;
    check("t4_err_cleared", err_o, 1'b0);

    // empty byteenable
    access(1'b0, 1'b1, 6'h05, 4'h0, 32'h0, 0, 1'b0);
    check("t5_readdata_lit", s1.readdata, 32'h0);

    // further patterns
    access(1'b1, 1'b0, 6'h03, 4'hF, 32'hDEADBEEF, 1, 1'b0);
    access(1'b0, 1'b1, 6'h03, 4'b0101, 32'h0, 1, 1'b0);
    access(1'b1, 1'b1, 6'h09, 4'b1001, 32'h11223344, 0, 1'b0);
    access(1'b0, 1'b1, 6'h3F, 4'hF, 32'h0, 2, 1'b0);

    // interrupt pass-through
    irq_pat = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      m1.irq = irq_pat[i];
    end
    @(negedge clk);
    m1.irq = 1'b0;
    repeat (2) @(negedge clk);

    // reset during lane 2 of a 4-lane write
    log_q.delete();
    stall_n = 0;
    s1.chipselect = 1'b1; s1.write = 1'b1; s1.read = 1'b0;
    s1.address = 6'h05; s1.byteenable = 4'hF; s1.writedata = 32'h01020304;
    repeat (3) @(posedge clk);
    #1;
    check("t6_lane2_write", m1.write, 1'b1);
    check("t6_lane2_addr", m1.address, 8'h16);
    #2 rst = 1'b1;
    #1;
    check("t6_write_drop", m1.write, 1'b0);
    check("t6_cs_drop", m1.chipselect, 1'b0);
    s1.chipselect = 1'b0; s1.write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t6_waitreq_idle", s1.waitrequest, 1'b1);
    repeat (4) @(negedge clk);
    check("t6_dn_count", log_q.size(), 2);

    // block is back in IDLE and fully functional
    access(1'b0, 1'b1, 6'h01, 4'b0110, 32'h0, 0, 1'b0);
    check("t7_readdata_lit", s1.readdata, 32'h00332200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
